// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, reset/NOP defaults and
// instruction field positions used by the fetch stage and decode.
package mips_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

    // Upper PC bits kept by j/jal (the 256 MB region of the delay-slot PC).
    localparam logic [31:0] PC_REGION_MASK = 32'hF000_0000;
    localparam logic [31:0] WORD_MASK      = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Redirect priority (jr > jump > branch) and word-aligned target formation.
module pc_next_mux
    import mips_pkg::*;
(
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [31:0] ifid_pc4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        redirect,
    output logic [31:0] target
);

    logic [31:0] jump_target;

    assign jump_target = (ifid_pc4 & PC_REGION_MASK) | {4'b0000, jump_index, 2'b00};

    always_comb begin
        redirect = jr | jump | branch_taken;
        target   = align_word(branch_target);
        if (jr) begin
            target = align_word(jr_target);
        end else if (jump) begin
            target = jump_target;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register for the MIPS core.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic [5:0]  op,
    output logic [4:0]  rt,
    output logic [5:0]  funct
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] wait_count
`endif
);

    fetch_state_t state;
    logic         kill;
    logic [31:0]  skid;
    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic         pending;
    logic         take;
    logic [31:0]  take_instr;
    logic         ifid_load;

    pc_next_mux u_pc_next_mux (
        .jr            (jr),
        .jr_target     (jr_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .ifid_pc4      (ifid_pc4),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .redirect      (redirect),
        .target        (target)
    );

    assign pc_plus4 = pc + 32'd4;
    assign pending  = imem_req & ~imem_ready;

    assign op    = ifid_instr[OP_MSB:OP_LSB];
    assign rt    = ifid_instr[RT_MSB:RT_LSB];
    assign funct = ifid_instr[FUNCT_MSB:FUNCT_LSB];

    // An instruction moves into IF/ID either straight from memory or from
    // the skid register once the decode stall releases.
    always_comb begin
        take       = 1'b0;
        take_instr = imem_rdata;
        if (!redirect && !kill) begin
            if (state == HOLD) begin
                take       = ~stall;
                take_instr = skid;
            end else if (imem_req && imem_ready && !stall) begin
                take = 1'b1;
            end
        end
    end

    assign ifid_load = take & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= REQ;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            kill      <= 1'b0;
            skid      <= NOP_INSTR;
        end else if (redirect) begin
            pc <= target;
            // An outstanding request keeps its address until its response is
            // swallowed; only then is the target issued.
            if (pending) begin
                kill  <= 1'b1;
                state <= WAIT;
            end else begin
                kill      <= 1'b0;
                state     <= REQ;
                imem_req  <= 1'b1;
                imem_addr <= target;
            end
        end else if (kill) begin
            if (imem_ready) begin
                kill      <= 1'b0;
                state     <= REQ;
                imem_addr <= pc;
            end
        end else begin
            case (state)
                REQ, WAIT: begin
                    if (!imem_req) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end else if (imem_ready) begin
                        if (stall) begin
                            skid     <= imem_rdata;
                            state    <= HOLD;
                            imem_req <= 1'b0;
                        end else begin
                            pc        <= pc_plus4;
                            imem_addr <= pc_plus4;
                            state     <= REQ;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc        <= pc_plus4;
                        imem_addr <= pc_plus4;
                        imem_req  <= 1'b1;
                        state     <= REQ;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= '0;
        end else if (redirect || flush) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= '0;
        end else if (take) begin
            ifid_valid <= 1'b1;
            ifid_instr <= take_instr;
            ifid_pc4   <= pc_plus4;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
            wait_count  <= '0;
        end else begin
            if (ifid_load) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if ((state == REQ || state == WAIT) && !imem_ready) begin
                wait_count <= wait_count + 32'd1;
            end
        end
    end
`else
    logic unused_load;
    assign unused_load = ifid_load;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (handshake, stall, redirects,
// kill of in-flight data, flush, PC wrap).
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [5:0]  funct;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] wait_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .op            (op),
        .rt            (rt),
        .funct         (funct)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count),
        .wait_count    (wait_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        imem_ready = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        step();
        step();
        vectors++;
        if ({imem_req, pc} !== {1'b0, 32'h0}) begin
            $display("FAIL reset_pc_req: got req=%b pc=%h expected req=0 pc=00000000", imem_req, pc);
            miscompares++;
        end
        vectors++;
        if ({ifid_valid, ifid_instr, ifid_pc4} !== {1'b0, 32'h0, 32'h0}) begin
            $display("FAIL reset_ifid: got v=%b instr=%h pc4=%h expected 0/0/0", ifid_valid, ifid_instr, ifid_pc4);
            miscompares++;
        end
        vectors++;
        if ({op, rt, funct} !== 17'h0) begin
            $display("FAIL reset_fields: got op=%h rt=%h funct=%h expected 0", op, rt, funct);
            miscompares++;
        end
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if (fetch_count !== 32'd0) begin
            $display("FAIL reset_fetch_count: got %0d expected 0", fetch_count);
            miscompares++;
        end
`endif
        imem_ready = 1'b0;
        rst = 1'b0;
        step();
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr);
            miscompares++;
        end
    endtask

    task automatic test_sequential_fetch();
        imem_ready = 1'b1;
        imem_rdata = 32'h2008_0005;
        step();
        vectors++;
        if ({ifid_valid, ifid_instr, ifid_pc4} !== {1'b1, 32'h2008_0005, 32'h4}) begin
            $display("FAIL seq_ifid0: got v=%b instr=%h pc4=%h expected 1/20080005/00000004", ifid_valid, ifid_instr, ifid_pc4);
            miscompares++;
        end
        vectors++;
        if ({op, rt, imem_addr} !== {6'h08, 5'h08, 32'h4}) begin
            $display("FAIL seq_fields0: got op=%h rt=%h addr=%h expected op=08 rt=08 addr=00000004", op, rt, imem_addr);
            miscompares++;
        end
        imem_rdata = 32'h0109_5020;
        step();
        vectors++;
        if ({ifid_instr, funct, ifid_pc4, imem_addr} !== {32'h0109_5020, 6'h20, 32'h8, 32'h8}) begin
            $display("FAIL seq_ifid1: got instr=%h funct=%h pc4=%h addr=%h expected 01095020/20/00000008/00000008", ifid_instr, funct, ifid_pc4, imem_addr);
            miscompares++;
        end
        imem_ready = 1'b0;
    endtask

    task automatic test_delayed_ready();
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({imem_req, imem_addr, ifid_valid, ifid_instr} !== {1'b1, 32'h8, 1'b1, 32'h0109_5020}) begin
                $display("FAIL wait_hold_%0d: got req=%b addr=%h v=%b instr=%h expected 1/00000008/1/01095020", i, imem_req, imem_addr, ifid_valid, ifid_instr);
                miscompares++;
            end
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h3C01_1001;
        step();
        vectors++;
        if ({ifid_instr, ifid_pc4, imem_addr} !== {32'h3C01_1001, 32'hC, 32'hC}) begin
            $display("FAIL wait_accept: got instr=%h pc4=%h addr=%h expected 3c011001/0000000c/0000000c", ifid_instr, ifid_pc4, imem_addr);
            miscompares++;
        end
        imem_ready = 1'b0;
        step();
        vectors++;
        if ({ifid_pc4, imem_addr, pc} !== {32'hC, 32'hC, 32'hC}) begin
            $display("FAIL no_duplicate: got pc4=%h addr=%h pc=%h expected 0000000c x3", ifid_pc4, imem_addr, pc);
            miscompares++;
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hAC0A_0000;
        step();
        imem_ready = 1'b0;
        vectors++;
        if ({ifid_instr, pc, imem_req} !== {32'h3C01_1001, 32'hC, 1'b0}) begin
            $display("FAIL stall_park: got instr=%h pc=%h req=%b expected 3c011001/0000000c/0", ifid_instr, pc, imem_req);
            miscompares++;
        end
        step();
        vectors++;
        if ({ifid_instr, pc} !== {32'h3C01_1001, 32'hC}) begin
            $display("FAIL stall_hold: got instr=%h pc=%h expected 3c011001/0000000c", ifid_instr, pc);
            miscompares++;
        end
        stall = 1'b0;
        step();
        vectors++;
        if ({ifid_valid, ifid_instr, ifid_pc4, pc, imem_req, imem_addr} !== {1'b1, 32'hAC0A_0000, 32'h10, 32'h10, 1'b1, 32'h10}) begin
            $display("FAIL stall_release: got v=%b instr=%h pc4=%h pc=%h req=%b addr=%h expected 1/ac0a0000/10/10/1/10", ifid_valid, ifid_instr, ifid_pc4, pc, imem_req, imem_addr);
            miscompares++;
        end
    endtask

    task automatic test_jump();
        branch_taken = 1'b1;
        branch_target = 32'h1000_0005;
        imem_ready = 1'b1;
        imem_rdata = 32'h1111_1111;
        step();
        branch_taken = 1'b0;
        vectors++;
        if ({pc, imem_addr, ifid_valid, ifid_instr} !== {32'h1000_0004, 32'h1000_0004, 1'b0, 32'h0}) begin
            $display("FAIL branch_redirect: got pc=%h addr=%h v=%b instr=%h expected 10000004/10000004/0/0", pc, imem_addr, ifid_valid, ifid_instr);
            miscompares++;
        end
        imem_rdata = 32'h0800_0010;
        step();
        vectors++;
        if ({ifid_instr, ifid_pc4} !== {32'h0800_0010, 32'h1000_0008}) begin
            $display("FAIL jump_setup: got instr=%h pc4=%h expected 08000010/10000008", ifid_instr, ifid_pc4);
            miscompares++;
        end
        jump = 1'b1;
        jump_index = 26'h000_0010;
        imem_rdata = 32'h2222_2222;
        step();
        jump = 1'b0;
        vectors++;
        if ({imem_addr, ifid_valid} !== {32'h1000_0040, 1'b0}) begin
            $display("FAIL jump_target: got addr=%h v=%b expected 10000040/0", imem_addr, ifid_valid);
            miscompares++;
        end
        imem_rdata = 32'h014B_4820;
        step();
        vectors++;
        if ({ifid_valid, ifid_instr, ifid_pc4} !== {1'b1, 32'h014B_4820, 32'h1000_0044}) begin
            $display("FAIL jump_refill: got v=%b instr=%h pc4=%h expected 1/014b4820/10000044", ifid_valid, ifid_instr, ifid_pc4);
            miscompares++;
        end
    endtask

    task automatic test_jr_priority();
        jr = 1'b1;
        jr_target = 32'h0000_0203;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0400;
        imem_rdata = 32'h3333_3333;
        step();
        jr = 1'b0;
        branch_taken = 1'b0;
        vectors++;
        if ({imem_addr, pc, ifid_valid} !== {32'h200, 32'h200, 1'b0}) begin
            $display("FAIL jr_priority: got addr=%h pc=%h v=%b expected 00000200/00000200/0", imem_addr, pc, ifid_valid);
            miscompares++;
        end
        imem_rdata = 32'h8D09_0004;
        step();
        jump = 1'b1;
        jump_index = 26'h000_0003;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0800;
        imem_rdata = 32'h4444_4444;
        step();
        jump = 1'b0;
        branch_taken = 1'b0;
        imem_ready = 1'b0;
        vectors++;
        if (imem_addr !== 32'hC) begin
            $display("FAIL jump_over_branch: got addr=%h expected 0000000c", imem_addr);
            miscompares++;
        end
    endtask

    task automatic test_redirect_in_wait();
        step();
        branch_taken = 1'b1;
        branch_target = 32'h0000_0100;
        step();
        branch_taken = 1'b0;
        vectors++;
        if ({imem_req, imem_addr, pc} !== {1'b1, 32'hC, 32'h100}) begin
            $display("FAIL kill_addr_held: got req=%b addr=%h pc=%h expected 1/0000000c/00000100", imem_req, imem_addr, pc);
            miscompares++;
        end
        step();
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        vectors++;
        if ({ifid_valid, ifid_instr, imem_addr} !== {1'b0, 32'h0, 32'h100}) begin
            $display("FAIL kill_drop: got v=%b instr=%h addr=%h expected 0/00000000/00000100", ifid_valid, ifid_instr, imem_addr);
            miscompares++;
        end
        imem_rdata = 32'h2402_0001;
        step();
        imem_ready = 1'b0;
        vectors++;
        if ({ifid_valid, ifid_instr, ifid_pc4, imem_addr} !== {1'b1, 32'h2402_0001, 32'h104, 32'h104}) begin
            $display("FAIL kill_target_fetch: got v=%b instr=%h pc4=%h addr=%h expected 1/24020001/104/104", ifid_valid, ifid_instr, ifid_pc4, imem_addr);
            miscompares++;
        end
    endtask

    task automatic test_flush_wrap();
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++;
        if ({ifid_valid, ifid_instr, pc} !== {1'b0, 32'h0, 32'h104}) begin
            $display("FAIL flush: got v=%b instr=%h pc=%h expected 0/00000000/00000104", ifid_valid, ifid_instr, pc);
            miscompares++;
        end
        jr = 1'b1;
        jr_target = 32'hFFFF_FFFF;
        imem_ready = 1'b1;
        imem_rdata = 32'h7777_7777;
        step();
        jr = 1'b0;
        vectors++;
        if ({pc, imem_addr} !== {32'hFFFF_FFFC, 32'hFFFF_FFFC}) begin
            $display("FAIL wrap_setup: got pc=%h addr=%h expected fffffffc x2", pc, imem_addr);
            miscompares++;
        end
        imem_rdata = 32'h1234_5678;
        step();
        vectors++;
        if ({ifid_instr, ifid_pc4, imem_addr, pc} !== {32'h1234_5678, 32'h0, 32'h0, 32'h0}) begin
            $display("FAIL pc_wrap: got instr=%h pc4=%h addr=%h pc=%h expected 12345678/0/0/0", ifid_instr, ifid_pc4, imem_addr, pc);
            miscompares++;
        end
    endtask

    task automatic test_redirect_over_stall();
        stall = 1'b1;
        imem_rdata = 32'h5555_5555;
        step();
        imem_ready = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0300;
        step();
        branch_taken = 1'b0;
        vectors++;
        if ({pc, imem_req, imem_addr, ifid_valid} !== {32'h300, 1'b1, 32'h300, 1'b0}) begin
            $display("FAIL redirect_stall: got pc=%h req=%b addr=%h v=%b expected 300/1/300/0", pc, imem_req, imem_addr, ifid_valid);
            miscompares++;
        end
        stall = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h6666_6666;
        step();
        imem_ready = 1'b0;
        vectors++;
        if ({ifid_instr, ifid_pc4} !== {32'h6666_6666, 32'h304}) begin
            $display("FAIL skid_discard: got instr=%h pc4=%h expected 66666666/00000304", ifid_instr, ifid_pc4);
            miscompares++;
        end
        stall = 1'b1;
        flush = 1'b1;
        step();
        stall = 1'b0;
        flush = 1'b0;
        vectors++;
        if ({ifid_valid, ifid_instr} !== {1'b0, 32'h0}) begin
            $display("FAIL flush_over_stall: got v=%b instr=%h expected 0/00000000", ifid_valid, ifid_instr);
            miscompares++;
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        vectors++;
        if (fetch_count !== 32'd10) begin
            $display("FAIL fetch_count: got %0d expected 10", fetch_count);
            miscompares++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential_fetch();
        test_delayed_ready();
        test_stall();
        test_jump();
        test_jr_priority();
        test_redirect_in_wait();
        test_flush_wrap();
        test_redirect_over_stall();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
